// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and memory-wait freeze sequencing for a 5-stage pipeline.
// Ports: clk/rst_n (async active-low); hazard inputs id_ex_*, if_id_*, ex_branch_taken, dmem_req/dmem_ready;
// controls pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold; hz_state (0 RUN, 1 STALL, 2 MEM_WAIT);
// perf_*_cnt saturating counters, live only when HAZARD_PERF_CNT_EN is defined, otherwise tied to 0.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_uses_rs1,
  input  logic        if_id_uses_rs2,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_hold,
  output logic [1:0]  hz_state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2} st_t;
  st_t state, ret_state, nstate, nret, eff;
  logic [CNT_W-1:0] cnt, ncnt;
  logic lu, frz;
  assign lu = id_ex_mem_read & (id_ex_rd != 5'd0) &
              ((if_id_uses_rs1 & (if_id_rs1 == id_ex_rd)) | (if_id_uses_rs2 & (if_id_rs2 == id_ex_rd)));
  // Leaving MEM_WAIT applies the saved state's rules in the same cycle, so there is no dead cycle.
  assign eff = (state == MEM_WAIT) ? ret_state : state;
  assign frz = (state == MEM_WAIT) ? ~dmem_ready : (dmem_req & ~dmem_ready);
  assign hz_state = state;
  always_comb begin
    pc_write = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold = 1'b0;
    nstate = state;
    nret = ret_state;
    ncnt = cnt;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frz) begin
      pipe_hold = 1'b1;
      if (state != MEM_WAIT) begin
        nret = state;
        nstate = MEM_WAIT;
      end
    end else if (eff == STALL) begin
      id_ex_bubble = 1'b1;
      ncnt = cnt - 1'b1;
      nstate = (cnt == CNT_W'(1)) ? RUN : STALL;
    end else if (ex_branch_taken) begin
      pc_write = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
      nstate = RUN;
    end else if (lu) begin
      id_ex_bubble = 1'b1;
      ncnt = CNT_W'(LOAD_STALL_CYCLES - 1);
      nstate = (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
    end else begin
      pc_write = 1'b1;
      if_id_write = 1'b1;
      nstate = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      ret_state <= RUN;
      cnt <= '0;
    end else begin
      state <= nstate;
      ret_state <= nret;
      cnt <= ncnt;
    end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps, pf, pw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps <= '0;
      pf <= '0;
      pw <= '0;
    end else begin
      if (id_ex_bubble & ~if_id_flush & (ps != '1)) ps <= ps + 32'd1;
      if (if_id_flush & (pf != '1)) pf <= pf + 32'd1;
      if (pipe_hold & (pw != '1)) pw <= pw + 32'd1;
    end
  assign perf_stall_cnt = ps;
  assign perf_flush_cnt = pf;
  assign perf_wait_cnt = pw;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
  assign perf_wait_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench driving LOAD_STALL_CYCLES=1 and =3 instances with shared directed vectors.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mr = 1'b0, u1 = 1'b0, u2 = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic pc_a, ifw_a, fl_a, bub_a, hold_a, pc_b, ifw_b, fl_b, bub_b, hold_b;
  logic [1:0] st_a, st_b;
  logic [31:0] ps_a, pf_a, pw_a, ps_b, pf_b, pw_b;
  typedef struct {
    logic [6:0] e1;
    logic [6:0] e3;
    logic [31:0] ps;
    logic [31:0] pf;
    logic [31:0] pw;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] acc_s = 0, acc_f = 0, acc_w = 0;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .ex_branch_taken(br), .dmem_req(req), .dmem_ready(rdy),
    .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(fl_a), .id_ex_bubble(bub_a), .pipe_hold(hold_a),
    .hz_state(st_a), .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a), .perf_wait_cnt(pw_a));
  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .ex_branch_taken(br), .dmem_req(req), .dmem_ready(rdy),
    .pc_write(pc_b), .if_id_write(ifw_b), .if_id_flush(fl_b), .id_ex_bubble(bub_b), .pipe_hold(hold_b),
    .hz_state(st_b), .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b), .perf_wait_cnt(pw_b));
  // Expected vectors are {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, hz_state}.
  task automatic step(input logic rn, input logic m, input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic a1, input logic a2, input logic b, input logic rq, input logic rr,
                      input logic [6:0] e1, input logic [6:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; mr = m; rd = d; rs1 = r1; rs2 = r2; u1 = a1; u2 = a2; br = b; req = rq; rdy = rr;
    if (!rn) begin
      acc_s = 0; acc_f = 0; acc_w = 0;
    end
    e.e1 = e1;
    e.e3 = e3;
`ifdef HAZARD_PERF_CNT_EN
    e.ps = acc_s; e.pf = acc_f; e.pw = acc_w;
`else
    e.ps = 0; e.pf = 0; e.pw = 0;
`endif
    q.push_back(e);
    if (rn) begin
      acc_s += 32'(e3[3] & ~e3[4]);
      acc_f += 32'(e3[4]);
      acc_w += 32'(e3[2]);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 3;
      if ({pc_a, ifw_a, fl_a, bub_a, hold_a, st_a} !== e.e1) begin
        errors++;
        $display("FAIL l1_ctrl t=%0t got %b want %b", $time, {pc_a, ifw_a, fl_a, bub_a, hold_a, st_a}, e.e1);
      end
      if ({pc_b, ifw_b, fl_b, bub_b, hold_b, st_b} !== e.e3) begin
        errors++;
        $display("FAIL l3_ctrl t=%0t got %b want %b", $time, {pc_b, ifw_b, fl_b, bub_b, hold_b, st_b}, e.e3);
      end
      if ({ps_b, pf_b, pw_b} !== {e.ps, e.pf, e.pw}) begin
        errors++;
        $display("FAIL l3_perf t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time, ps_b, pf_b, pw_b, e.ps, e.pf, e.pw);
      end
    end
  localparam logic [6:0] RST = 7'b00110_00, NRM = 7'b11000_00, LUB = 7'b00010_00, STB = 7'b00010_01;
  localparam logic [6:0] FRR = 7'b00001_00, FRS = 7'b00001_01, FRW = 7'b00001_10, FLU = 7'b11110_00;
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, LUB, LUB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, STB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, STB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, NRM, NRM);
    step(1, 1, 5, 5, 0, 1, 0, 1, 0, 0, FLU, FLU);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRR, FRR);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRW, FRW);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRW, FRW);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRW, FRW);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b11000_10, 7'b11000_10);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, LUB, LUB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRR, FRS);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRW, FRW);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b11000_10, 7'b00010_10);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, STB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    step(1, 1, 7, 3, 7, 1, 1, 0, 0, 0, LUB, LUB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, STB);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, STB);
    step(1, 1, 9, 9, 9, 0, 0, 0, 0, 0, NRM, NRM);
    step(1, 1, 5, 5, 0, 1, 0, 1, 1, 0, FRR, FRR);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRW, FRW);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, RST);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, NRM);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
